// File: rtl/board_reset_strap_pkg.sv
// Shared state encodings, default timing constants and strap helpers for the
// board-level reset and mode-strap conditioning logic.
package board_reset_strap_pkg;

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_RST_HOLD_CYCLES = 16;

    typedef struct packed {
        logic boot;
        logic prog;
    } strap_t;

    function automatic logic strap_differs(input strap_t live, input strap_t held);
        return (live.boot != held.boot) | (live.prog != held.prog);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-or-more flop synchroniser followed by a counter debouncer; a new level is
// accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   stable_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign stable   = stable_r;

    // Synchroniser chain for the asynchronous raw pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce counter: any return to the stable level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (synced_s == stable_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= synced_s;
            cnt_r    <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/board_reset_strap.sv
// Conditions the board reset button and mode switches, stretches the SoC reset
// and freezes the boot/prog straps once per reset release.
module board_reset_strap
    import board_reset_strap_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_rstn,
    input  logic       i_boot_mode,
    input  logic       i_prog_mode,
    output logic       o_sys_rstn,
    output logic       o_boot_mode,
    output logic       o_prog_mode,
    output logic       o_boot_led,
    output logic       o_strap_mismatch,
    output logic [1:0] o_state
);

    localparam int             HCW       = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

    logic           rstn_db_s;
    strap_t         live_s;
    logic [1:0]     state_r,    state_nxt_s;
    logic [HCW-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic           sys_rstn_r, sys_rstn_nxt_s;
    strap_t         strap_r,    strap_nxt_s;
    logic           mismatch_r, mismatch_nxt_s;

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(i_clk), .rst(i_rst), .raw(i_btn_rstn), .stable(rstn_db_s)
    );
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_boot (
        .clk(i_clk), .rst(i_rst), .raw(i_boot_mode), .stable(live_s.boot)
    );
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prog (
        .clk(i_clk), .rst(i_rst), .raw(i_prog_mode), .stable(live_s.prog)
    );

    // Next-state logic; a pressed button overrides every state
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        sys_rstn_nxt_s = sys_rstn_r;
        strap_nxt_s    = strap_r;
        if (!rstn_db_s) begin
            state_nxt_s    = ST_HOLD;
            hold_cnt_nxt_s = '0;
            sys_rstn_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s    = ST_SAMPLE;
                        hold_cnt_nxt_s = '0;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                    end
                end
                ST_SAMPLE: begin
                    strap_nxt_s    = live_s;
                    sys_rstn_nxt_s = 1'b1;
                    state_nxt_s    = ST_RUN;
                end
                ST_RUN: begin
                    sys_rstn_nxt_s = 1'b1;
                end
                default: begin
                    state_nxt_s    = ST_HOLD;
                    hold_cnt_nxt_s = '0;
                    sys_rstn_nxt_s = 1'b0;
                end
            endcase
        end
        mismatch_nxt_s = (state_r == ST_RUN) & strap_differs(live_s, strap_r);
    end

    // State, counter and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= '0;
            sys_rstn_r <= 1'b0;
            strap_r    <= '0;
            mismatch_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            sys_rstn_r <= sys_rstn_nxt_s;
            strap_r    <= strap_nxt_s;
            mismatch_r <= mismatch_nxt_s;
        end
    end

    assign o_sys_rstn       = sys_rstn_r;
    assign o_boot_mode      = strap_r.boot;
    assign o_prog_mode      = strap_r.prog;
    assign o_boot_led       = strap_r.boot;
    assign o_strap_mismatch = mismatch_r;
    assign o_state          = state_r;

endmodule

// File: tb/tb_board_reset_strap.sv
// Self-checking bench: power-up vector table, directed corner sequences and a
// randomized run checked every cycle against a windowed reference model.
module tb_board_reset_strap;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 4;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_btn_rstn;
    logic       i_boot_mode;
    logic       i_prog_mode;
    logic       o_sys_rstn;
    logic       o_boot_mode;
    logic       o_prog_mode;
    logic       o_boot_led;
    logic       o_strap_mismatch;
    logic [1:0] o_state;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;

    board_reset_strap #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RST_HOLD_CYCLES(HOLD)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn_rstn(i_btn_rstn),
        .i_boot_mode(i_boot_mode), .i_prog_mode(i_prog_mode),
        .o_sys_rstn(o_sys_rstn), .o_boot_mode(o_boot_mode), .o_prog_mode(o_prog_mode),
        .o_boot_led(o_boot_led), .o_strap_mismatch(o_strap_mismatch), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    assign outs = {o_sys_rstn, o_boot_mode, o_prog_mode, o_boot_led, o_strap_mismatch, o_state};

    // Reference model: per-edge histories; bit0 button, bit1 boot, bit2 prog
    logic [2:0] raw_q[$];
    logic [2:0] syn_q[$];
    logic [2:0] db_q[$];
    logic [2:0] m_stable;
    logic       m_rstn, m_boot, m_prog, m_mis;
    logic [1:0] m_state;
    int         m_n;

    task automatic model_reset();
        raw_q.delete(); syn_q.delete(); db_q.delete();
        m_stable = 3'b000; m_rstn = 1'b0; m_boot = 1'b0; m_prog = 1'b0;
        m_mis = 1'b0; m_state = 2'd0; m_n = 0;
    endtask

    task automatic model_step();
        logic [2:0] syn, dbpre;
        logic       all_diff, new_rstn, win;
        m_n++;
        raw_q.push_back({i_prog_mode, i_boot_mode, i_btn_rstn});
        syn = (m_n > SYNC) ? raw_q[m_n - SYNC - 1] : 3'b000;
        syn_q.push_back(syn);
        dbpre = m_stable;
        // a level is accepted after DEB consecutive synced samples differ from it
        if (m_n >= DEB) begin
            for (int b = 0; b < 3; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (syn_q[m_n - 1 - k][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
        end
        db_q.push_back(dbpre);
        new_rstn = 1'b0;
        if (m_n > HOLD) begin
            new_rstn = 1'b1;
            for (int k = 0; k <= HOLD; k++) if (!db_q[m_n - 1 - k][0]) new_rstn = 1'b0;
        end
        win = 1'b0;
        if (m_n >= HOLD) begin
            win = 1'b1;
            for (int k = 0; k < HOLD; k++) if (!db_q[m_n - 1 - k][0]) win = 1'b0;
        end
        m_mis = m_rstn & ((dbpre[1] != m_boot) | (dbpre[2] != m_prog));
        if (!m_rstn && new_rstn) begin
            m_boot = dbpre[1];
            m_prog = dbpre[2];
        end
        m_state = new_rstn ? 2'd2 : (win ? 2'd1 : 2'd0);
        m_rstn  = new_rstn;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check("model", outs, {m_rstn, m_boot, m_prog, m_boot, m_mis, m_state});
    endtask

    // Called away from a rising edge; returns on a falling edge with reset released
    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        check("async_clear", outs, 7'b0000000);
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic press(input int n, output int fall_at);
        fall_at = 0;
        i_btn_rstn = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (!o_sys_rstn && fall_at == 0) fall_at = k;
        end
        i_btn_rstn = 1'b1;
    endtask

    task automatic wait_rise(output int rise_at);
        rise_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (o_sys_rstn && rise_at == 0) rise_at = k;
        end
    endtask

    typedef struct {
        logic       btn;
        logic       boot;
        logic       prog;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[16];
    int   fall_at, rise_at, mis_at;

    initial begin
        for (int r = 0; r < 16; r++) begin
            tbl[r].btn = 1'b1; tbl[r].boot = 1'b1; tbl[r].prog = 1'b0;
            tbl[r].exp = (r < 13) ? 7'b0000000 : ((r == 13) ? 7'b0000001 : 7'b1101010);
        end

        i_rst = 1'b0; i_btn_rstn = 1'b1; i_boot_mode = 1'b1; i_prog_mode = 1'b0;
        #2;
        do_reset();

        // power-up: release completes at edge 15
        for (int r = 0; r < 16; r++) begin
            i_btn_rstn = tbl[r].btn; i_boot_mode = tbl[r].boot; i_prog_mode = tbl[r].prog;
            step();
            check("powerup", outs, tbl[r].exp);
        end

        // glitch shorter than the debounce window
        i_btn_rstn = 1'b0;
        for (int k = 0; k < 5; k++) step();
        i_btn_rstn = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            check("glitch", {4'b0000, o_sys_rstn, o_state}, {4'b0000, 3'b110});
        end

        // long press then release
        press(20, fall_at);
        check_int("press_fall", fall_at, 11);
        wait_rise(rise_at);
        check_int("release_rise", rise_at, 15);

        // boot switch change while running
        i_boot_mode = 1'b0;
        mis_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (o_strap_mismatch && mis_at == 0) mis_at = k;
        end
        check_int("mismatch_at", mis_at, 11);
        check("strap_frozen", {6'b0, o_boot_mode}, 7'b0000001);
        press(20, fall_at);
        wait_rise(rise_at);
        check_int("relatch_rise", rise_at, 15);
        check("relatched", {5'b0, o_boot_mode, o_strap_mismatch}, 7'b0000000);

        // bouncy boot switch across the release window
        press(20, fall_at);
        rise_at = 0;
        for (int k = 1; k <= 30; k++) begin
            i_boot_mode = (k < 24) ? 1'(((k - 1) / 3) % 2) : 1'b1;
            step();
            if (o_sys_rstn && rise_at == 0) rise_at = k;
        end
        check_int("bouncy_rise", rise_at, 15);
        check("bouncy_latch", {6'b0, o_boot_mode}, 7'b0000000);

        // latch boot=1, then reset asynchronously with the hold counter at 2
        press(20, fall_at);
        wait_rise(rise_at);
        check("boot_one", {6'b0, o_boot_mode}, 7'b0000001);
        i_btn_rstn = 1'b0;
        for (int k = 0; k < 12; k++) step();
        i_btn_rstn = 1'b1;
        for (int k = 0; k < 12; k++) step();
        do_reset();
        wait_rise(rise_at);
        check_int("restart_rise", rise_at, 15);

        // randomized switches and button against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 11) == 0) i_btn_rstn = ~i_btn_rstn;
            if ($urandom_range(0, 15) == 0) i_boot_mode = ~i_boot_mode;
            if ($urandom_range(0, 15) == 0) i_prog_mode = ~i_prog_mode;
            step();
        end
        i_btn_rstn = 1'b1;
        for (int k = 0; k < 40; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
